mycpu_fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode stage. It owns the PC register and drives an SRAM-like instruction-memory request/response interface. It presents one fetched instruction plus its PC to decode through a valid/ready handshake. It applies control-transfer redirects reported by decode (C1 encoding, jmpAddr value) after the MIPS branch delay slot.

---
 rtl/mycpu_fetch_stage_pkg.sv | 18 +
 rtl/mycpu_next_pc.sv | 42 ++++
 rtl/mycpu_fetch_stage.sv | 103 ++++++++++
 tb/tb_mycpu_fetch_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mycpu_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } fetch_state_t;

    localparam logic [1:0] C1_SEQ = 2'b00;
    localparam logic [1:0] C1_REL = 2'b01;
    localparam logic [1:0] C1_ABS = 2'b10;
    localparam logic [1:0] C1_REG = 2'b11;

endpackage

// File: rtl/mycpu_next_pc.sv
// Branch/jump target computation and selection of the PC that follows an accepted fetch.
module mycpu_next_pc
    import mycpu_fetch_stage_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] fetch_pc,
    input  logic          redirect_pending,
    input  logic [AW-1:0] redirect_target,
    input  logic          br_valid,
    input  logic [1:0]    br_c1,
    input  logic [AW-1:0] br_pc,
    input  logic [AW-1:0] br_target,
    output logic          br_take_c,
    output logic [AW-1:0] target_c,
    output logic [AW-1:0] next_pc_c
);

    logic [AW-1:0] raw_target;

    // Relative transfers are measured from the delay slot; all targets are word aligned.
    always_comb begin
        raw_target = br_target;
        if (br_c1 == C1_REL) begin
            raw_target = br_pc + AW'(4) + br_target;
        end
        target_c = {raw_target[AW-1:2], 2'b00};
    end

    // A pulse arriving while a redirect is already queued would be a branch in a delay slot.
    assign br_take_c = br_valid && (br_c1 != C1_SEQ) && !redirect_pending;

    always_comb begin
        next_pc_c = fetch_pc + AW'(4);
        if (br_take_c) begin
            next_pc_c = target_c;
        end else if (redirect_pending) begin
            next_pc_c = redirect_target;
        end
    end

endmodule

// File: rtl/mycpu_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one SRAM-like request at a time and
// hands each fetched word to decode, applying redirects after the delay slot.
module mycpu_fetch_stage
    import mycpu_fetch_stage_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          inst_req,
    output logic [AW-1:0] inst_addr,
    input  logic          inst_addr_ok,
    input  logic          inst_data_ok,
    input  logic [31:0]   inst_rdata,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [AW-1:0] id_pc,
    output logic [31:0]   id_inst,
    input  logic          br_valid,
    input  logic [1:0]    br_c1,
    input  logic [AW-1:0] br_pc,
    input  logic [AW-1:0] br_target
);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] redirect_target;
    logic          redirect_pending;
    logic          br_take_c;
    logic [AW-1:0] target_c;
    logic [AW-1:0] next_pc_c;
    logic          addr_hs_c;
    logic          data_hs_c;

    mycpu_next_pc #(.AW(AW)) u_next_pc (
        .fetch_pc         (fetch_pc),
        .redirect_pending (redirect_pending),
        .redirect_target  (redirect_target),
        .br_valid         (br_valid),
        .br_c1            (br_c1),
        .br_pc            (br_pc),
        .br_target        (br_target),
        .br_take_c        (br_take_c),
        .target_c         (target_c),
        .next_pc_c        (next_pc_c)
    );

    assign addr_hs_c = (state == S_REQ) && inst_addr_ok;
    assign data_hs_c = (state == S_WAIT) && inst_data_ok;
    assign inst_addr = fetch_pc;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_REQ;
            S_REQ:   if (inst_addr_ok) state_next = S_WAIT;
            S_WAIT:  if (inst_data_ok) state_next = S_FULL;
            S_FULL:  if (id_ready)     state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            inst_req <= 1'b0;
            id_valid <= 1'b0;
        end else begin
            state    <= state_next;
            inst_req <= (state_next == S_REQ);
            id_valid <= (state_next == S_FULL);
        end
    end

    // PC, captured instruction and queued redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc         <= RESET_PC;
            id_pc            <= '0;
            id_inst          <= '0;
            redirect_pending <= 1'b0;
            redirect_target  <= '0;
        end else begin
            if (addr_hs_c) begin
                id_pc    <= fetch_pc;
                fetch_pc <= next_pc_c;
            end
            if (data_hs_c) begin
                id_inst <= inst_rdata;
            end
            if (addr_hs_c) begin
                redirect_pending <= 1'b0;
            end else if (br_take_c) begin
                redirect_pending <= 1'b1;
                redirect_target  <= target_c;
            end
        end
    end

endmodule

// File: tb/tb_mycpu_fetch_stage.sv
// Bench for mycpu_fetch_stage: cycle vector table, directed redirect/reset sequences,
// and a randomized run against an instruction-stream reference model.
module tb_mycpu_fetch_stage;
    import mycpu_fetch_stage_pkg::*;

    localparam int unsigned AW = 32;
    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [31:0]   inst_rdata;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [31:0]   id_inst;
    logic          br_valid;
    logic [1:0]    br_c1;
    logic [AW-1:0] br_pc;
    logic [AW-1:0] br_target;

    always #5 clk = ~clk;

    mycpu_fetch_stage #(.AW(AW), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .br_valid     (br_valid),
        .br_c1        (br_c1),
        .br_pc        (br_pc),
        .br_target    (br_target)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic        a_ok;
        logic        d_ok;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input logic a, input logic d, input logic r, input logic [31:0] rd,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.a_ok = a; v.d_ok = d; v.rdy = r; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    // Instruction memory contents as seen by the bench.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; id_ready = 1'b0;
        br_valid = 1'b0; br_c1 = C1_SEQ; br_pc = '0; br_target = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One complete fetch with single-cycle memory latency, optionally with a branch
    // pulse coinciding with the address handshake.
    task automatic run_fetch(input string name, input logic [31:0] exp_addr, input logic do_br,
                             input logic [1:0] c1, input logic [31:0] bpc, input logic [31:0] btgt);
        int k;
        k = 0;
        while (!inst_req && k < 20) begin
            step();
            k++;
        end
        check({name, "_req"}, 32'(inst_req), 32'd1);
        check({name, "_addr"}, inst_addr, exp_addr);
        inst_addr_ok = 1'b1;
        if (do_br) begin
            br_valid = 1'b1; br_c1 = c1; br_pc = bpc; br_target = btgt;
        end
        step();
        inst_addr_ok = 1'b0;
        br_valid     = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = memf(exp_addr);
        step();
        inst_data_ok = 1'b0;
        check({name, "_valid"}, 32'(id_valid), 32'd1);
        check({name, "_pc"}, id_pc, exp_addr);
        check({name, "_inst"}, id_inst, memf(exp_addr));
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
    endtask

    task automatic seq_fetch(input string name, input logic [31:0] a);
        run_fetch(name, a, 1'b0, C1_SEQ, '0, '0);
    endtask

    // Reference-model state for the randomized run.
    logic [31:0] exp_fetch, last_fetched, slot_pc, slot_tgt, out_addr;
    logic [31:0] bpc, btgt, tgt, s_addr, s_pc, s_inst;
    logic [1:0]  bc1;
    logic        slot_valid, last_slot, br_armed, outstanding;
    logic        s_req, s_valid, a_ok, d_ok, rdy, fire;
    int          br_wait, lat, deliveries;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] i0, i1, i2;
        i0 = 32'h1000_0001; i1 = 32'h2000_0002; i2 = 32'h3000_0003;
        //           a  d  r  rdata           req addr         v  pc           inst
        vt[0]  = mk(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,       32'h0);
        vt[1]  = mk(0, 0, 0, 32'h0,          1, RPC,          0, 32'h0,       32'h0);
        vt[2]  = mk(1, 0, 0, 32'h0,          1, RPC,          0, 32'h0,       32'h0);
        vt[3]  = mk(0, 0, 0, 32'h0,          0, 32'h0,        0, RPC,         32'h0);
        vt[4]  = mk(0, 1, 0, i0,             0, 32'h0,        0, RPC,         32'h0);
        vt[5]  = mk(0, 0, 1, 32'h0,          0, 32'h0,        1, RPC,         i0);
        vt[6]  = mk(1, 0, 0, 32'h0,          1, RPC + 32'h4,  0, RPC,         i0);
        vt[7]  = mk(0, 1, 0, i1,             0, 32'h0,        0, RPC + 32'h4, i0);
        vt[8]  = mk(0, 0, 0, 32'h0,          0, 32'h0,        1, RPC + 32'h4, i1);
        vt[9]  = mk(0, 1, 0, 32'hDEAD_BEEF,  0, 32'h0,        1, RPC + 32'h4, i1);
        vt[10] = mk(1, 0, 0, 32'h0,          0, 32'h0,        1, RPC + 32'h4, i1);
        vt[11] = mk(0, 0, 0, 32'h0,          0, 32'h0,        1, RPC + 32'h4, i1);
        vt[12] = mk(0, 0, 0, 32'h0,          0, 32'h0,        1, RPC + 32'h4, i1);
        vt[13] = mk(0, 0, 1, 32'h0,          0, 32'h0,        1, RPC + 32'h4, i1);
        vt[14] = mk(1, 0, 0, 32'h0,          1, RPC + 32'h8,  0, RPC + 32'h4, i1);
        vt[15] = mk(0, 1, 0, i2,             0, 32'h0,        0, RPC + 32'h8, i1);
        vt[16] = mk(0, 0, 1, 32'h0,          0, 32'h0,        1, RPC + 32'h8, i2);
        vt[17] = mk(0, 0, 0, 32'h0,          1, RPC + 32'hC,  0, RPC + 32'h8, i2);

        do_reset();
        check("reset_addr", inst_addr, RPC);
        for (int i = 0; i < 18; i++) begin
            check($sformatf("vec%0d_req", i), 32'(inst_req), 32'(vt[i].e_req));
            if (vt[i].e_req) check($sformatf("vec%0d_addr", i), inst_addr, vt[i].e_addr);
            check($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(vt[i].e_valid));
            check($sformatf("vec%0d_pc", i), id_pc, vt[i].e_pc);
            check($sformatf("vec%0d_inst", i), id_inst, vt[i].e_inst);
            inst_addr_ok = vt[i].a_ok;
            inst_data_ok = vt[i].d_ok;
            inst_rdata   = vt[i].rdata;
            id_ready     = vt[i].rdy;
            step();
        end

        // Relative branch reported before the delay slot is accepted; c1=00 pulse ignored.
        do_reset();
        seq_fetch("rel_f0", RPC);
        run_fetch("c1_seq_ignored", RPC + 32'h4, 1'b1, C1_SEQ, RPC, 32'h0000_0100);
        seq_fetch("rel_f2", RPC + 32'h8);
        seq_fetch("rel_f3", RPC + 32'hC);
        seq_fetch("rel_br", RPC + 32'h10);
        br_valid = 1'b1; br_c1 = C1_REL; br_pc = RPC + 32'h10; br_target = 32'hFFFF_FFF0;
        step();
        br_valid = 1'b0;
        seq_fetch("rel_slot", RPC + 32'h14);
        seq_fetch("rel_tgt", RPC + 32'h4);

        // Register jump coinciding with the delay-slot handshake, then absolute jump to wrap.
        do_reset();
        for (int i = 0; i < 9; i++) seq_fetch($sformatf("reg_f%0d", i), RPC + 32'(4 * i));
        run_fetch("reg_slot", RPC + 32'h24, 1'b1, C1_REG, RPC + 32'h20, 32'h8000_1003);
        seq_fetch("reg_tgt", 32'h8000_1000);
        run_fetch("abs_slot_w", 32'h8000_1004, 1'b1, C1_ABS, 32'h8000_1000, 32'hFFFF_FFFE);
        seq_fetch("wrap_a", 32'hFFFF_FFFC);
        seq_fetch("wrap_b", 32'h0000_0000);

        // Absolute jump queued, then further pulses while pending are ignored.
        do_reset();
        seq_fetch("abs_f0", RPC);
        seq_fetch("abs_br", RPC + 32'h4);
        br_valid = 1'b1; br_c1 = C1_ABS; br_pc = RPC + 32'h4; br_target = RPC + 32'h100;
        step();
        br_c1 = C1_REL; br_pc = RPC + 32'h8; br_target = 32'h40;
        step();
        br_valid = 1'b0;
        run_fetch("abs_slot", RPC + 32'h8, 1'b1, C1_REG, RPC + 32'h8, 32'h1234_5678);
        seq_fetch("abs_tgt", RPC + 32'h100);
        seq_fetch("abs_next", RPC + 32'h104);

        // Reset while waiting for data: stale response must be dropped.
        do_reset();
        step();
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        check("wait_pc", id_pc, RPC);
        rst = 1'b1;
        #1;
        check("arst_req", 32'(inst_req), 32'd0);
        check("arst_valid", 32'(id_valid), 32'd0);
        check("arst_pc", id_pc, 32'd0);
        check("arst_addr", inst_addr, RPC);
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        step();
        rst = 1'b0;
        step();
        inst_data_ok = 1'b0;
        check("stale_inst", id_inst, 32'd0);
        check("stale_valid", 32'(id_valid), 32'd0);
        seq_fetch("rst_restart", RPC);

        // Randomized run: bench acts as memory and decode, model tracks the program order.
        do_reset();
        exp_fetch = RPC; last_fetched = '0; slot_pc = '0; slot_tgt = '0; out_addr = '0;
        slot_valid = 0; last_slot = 0; br_armed = 0; outstanding = 0;
        br_wait = 0; lat = 0; deliveries = 0; bc1 = C1_SEQ; bpc = '0; btgt = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_req = inst_req; s_addr = inst_addr; s_valid = id_valid; s_pc = id_pc; s_inst = id_inst;
            a_ok = ($urandom_range(0, 3) != 0);
            fire = 1'b0;
            if (br_armed) begin
                if (br_wait == 0) begin
                    fire = 1'b1;
                    br_armed = 1'b0;
                end else begin
                    br_wait--;
                    a_ok = 1'b0;
                end
            end
            d_ok = 1'b0;
            inst_rdata = $urandom;
            if (outstanding) begin
                if (lat == 0) begin
                    d_ok = 1'b1;
                    inst_rdata = memf(out_addr);
                end else lat--;
            end else d_ok = ($urandom_range(0, 7) == 0);
            rdy = 1'($urandom_range(0, 1));
            inst_addr_ok = a_ok; inst_data_ok = d_ok; id_ready = rdy;
            if (fire) begin
                br_valid = 1'b1; br_c1 = bc1; br_pc = bpc; br_target = btgt;
            end else if ($urandom_range(0, 15) == 0) begin
                br_valid = 1'b1; br_c1 = C1_SEQ; br_pc = $urandom; br_target = $urandom;
            end else br_valid = 1'b0;

            if (outstanding && d_ok) outstanding = 1'b0;
            if (s_req && a_ok) begin
                check("rnd_fetch_addr", s_addr, exp_fetch);
                out_addr = s_addr;
                outstanding = 1'b1;
                lat = $urandom_range(0, 2);
                last_fetched = exp_fetch;
                last_slot = slot_valid && (exp_fetch == slot_pc);
                if (last_slot) begin
                    exp_fetch = slot_tgt;
                    slot_valid = 1'b0;
                end else exp_fetch = exp_fetch + 32'd4;
            end
            if (s_valid && rdy) begin
                check("rnd_pc", s_pc, last_fetched);
                check("rnd_inst", s_inst, memf(last_fetched));
                deliveries++;
                if (!last_slot && $urandom_range(0, 3) == 0) begin
                    bc1 = 2'($urandom_range(1, 3));
                    bpc = last_fetched;
                    if (bc1 == C1_REL) begin
                        btgt = $urandom & 32'h0000_0FFF;
                        if ($urandom_range(0, 1) == 1) btgt = 32'd0 - btgt;
                        tgt = last_fetched + 32'd4 + btgt;
                    end else begin
                        btgt = $urandom;
                        tgt = btgt;
                    end
                    slot_valid = 1'b1;
                    slot_pc    = last_fetched + 32'd4;
                    slot_tgt   = tgt & ~32'h3;
                    br_armed   = 1'b1;
                    br_wait    = $urandom_range(0, 2);
                end
            end
            step();
        end
        idle_inputs();
        check("rnd_deliveries", 32'(deliveries >= 150), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
